// File: rtl/card_sequencer.sv
// Command sequencer for a card-counting shoe: validates card/deck/back commands
// against the counter's deck/total, then issues one strobe or a rejection code.
module card_sequencer #(
  parameter int unsigned MAX_DECK   = 8,
  parameter int unsigned UNDO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cmd,
  input  logic [3:0]  in_rank,
  input  logic [7:0]  deck,
  input  logic [15:0] total,
  output logic        small_add,
  output logic        seven_add,
  output logic        large_add,
  output logic        deck_add,
  output logic        back,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [2:0]  undo_cnt
);

  localparam int unsigned DW             = 8;
  localparam int unsigned TW             = 16;
  localparam int unsigned EW             = 3;
  localparam int unsigned UW             = 3;
  localparam int unsigned SW             = 5;
  localparam int unsigned CARDS_PER_DECK = 52;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, REJECT} state_t;

  // Strobe vector bit order: {small, seven, large, deck_add, back}
  localparam logic [SW-1:0] S_SMALL = 5'b10000;
  localparam logic [SW-1:0] S_SEVEN = 5'b01000;
  localparam logic [SW-1:0] S_LARGE = 5'b00100;
  localparam logic [SW-1:0] S_DECK  = 5'b00010;
  localparam logic [SW-1:0] S_BACK  = 5'b00001;

  state_t          state, state_nx;
  logic [SW-1:0]   strobe_q, strobe_nx;
  logic            err_q, err_nx;
  logic [EW-1:0]   code_q, code_nx;
  logic [UW-1:0]   undo_q, undo_nx;
  logic [EW-1:0]   chk_code;
  logic [TW-1:0]   limit;
  logic            accept;

  assign in_ready = rst && (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Rejection cause for the offered command, first matching rule wins
  always_comb begin
    chk_code = '0;
    limit    = TW'(CARDS_PER_DECK) * TW'(deck);
    case (in_cmd)
      2'd0: begin
        if (in_rank == 4'd0 || in_rank > 4'd13) chk_code = EW'(2);
        else if (deck == '0)                    chk_code = EW'(3);
        else if (total >= limit)                chk_code = EW'(4);
      end
      2'd1: begin
        if (total != '0)                 chk_code = EW'(5);
        else if (deck >= DW'(MAX_DECK))  chk_code = EW'(6);
      end
      2'd2: begin
        if (undo_q == '0) chk_code = EW'(7);
      end
      default: chk_code = EW'(1);
    endcase
  end

  always_comb begin
    state_nx  = state;
    strobe_nx = '0;
    err_nx    = 1'b0;
    code_nx   = code_q;
    undo_nx   = undo_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (chk_code != '0) begin
            state_nx = REJECT;
            err_nx   = 1'b1;
            code_nx  = chk_code;
          end else begin
            state_nx = ISSUE;
            case (in_cmd)
              2'd0: begin
                if (in_rank >= 4'd2 && in_rank <= 4'd6)      strobe_nx = S_SMALL;
                else if (in_rank >= 4'd7 && in_rank <= 4'd9) strobe_nx = S_SEVEN;
                else                                         strobe_nx = S_LARGE;
                if (undo_q < UW'(UNDO_DEPTH)) undo_nx = undo_q + UW'(1);
              end
              2'd1: begin
                strobe_nx = S_DECK;
                undo_nx   = '0;
              end
              default: begin
                strobe_nx = S_BACK;
                undo_nx   = undo_q - UW'(1);
              end
            endcase
          end
        end
      end
      ISSUE:   state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      REJECT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      strobe_q <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      undo_q   <= '0;
    end else begin
      state    <= state_nx;
      strobe_q <= strobe_nx;
      err_q    <= err_nx;
      code_q   <= code_nx;
      undo_q   <= undo_nx;
    end
  end

  // Pulses are masked by reset so an aborted command never reaches the counter
  assign small_add = strobe_q[4] & rst;
  assign seven_add = strobe_q[3] & rst;
  assign large_add = strobe_q[2] & rst;
  assign deck_add  = strobe_q[1] & rst;
  assign back      = strobe_q[0] & rst;
  assign err       = err_q & rst;
  assign err_code  = code_q;
  assign undo_cnt  = undo_q;

endmodule

// File: tb/tb_card_sequencer.sv
// Bench for card_sequencer: directed scenarios with literal expectations plus
// random traffic checked every cycle against a transaction-level model.
module tb_card_sequencer;

  localparam int MAX_DECK   = 8;
  localparam int UNDO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_cmd = '0;
  logic [3:0]  in_rank = '0;
  logic [7:0]  deck = '0;
  logic [15:0] total = '0;
  logic        small_add, seven_add, large_add, deck_add, back, err;
  logic [2:0]  err_code, undo_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_back   = 0;

  card_sequencer #(.MAX_DECK(MAX_DECK), .UNDO_DEPTH(UNDO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_rank(in_rank), .deck(deck), .total(total),
    .small_add(small_add), .seven_add(seven_add), .large_add(large_add),
    .deck_add(deck_add), .back(back), .err(err), .err_code(err_code),
    .undo_cnt(undo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rules-level judgement: returns rejection code (0 = legal) and strobe index
  function automatic int judge(input int c, input int r, input int d, input int t,
                               input int u, output int kind);
    kind = -1;
    if (c == 3) return 1;
    if (c == 0) begin
      if (r < 1 || r > 13) return 2;
      if (d == 0) return 3;
      if (t >= 52 * d) return 4;
      kind = (r >= 2 && r <= 6) ? 0 : (r >= 7 && r <= 9) ? 1 : 2;
      return 0;
    end
    if (c == 1) begin
      if (t != 0) return 5;
      if (d >= MAX_DECK) return 6;
      kind = 3;
      return 0;
    end
    if (u == 0) return 7;
    kind = 4;
    return 0;
  endfunction

  // Model: m_busy counts the cycles the sequencer remains unavailable
  int m_busy = 0, m_str = -1, m_code = 0, m_undo = 0;
  bit m_err = 0, m_live = 0;

  always @(posedge clk) begin
    int c, k;
    if (!rst) begin
      m_busy = 0; m_str = -1; m_err = 0; m_code = 0; m_undo = 0; m_live = 1;
    end else begin
      m_str = -1;
      m_err = 0;
      if (m_busy > 0) m_busy--;
      else if (in_valid) begin
        c = judge(int'(in_cmd), int'(in_rank), int'(deck), int'(total), m_undo, k);
        if (c != 0) begin
          m_err = 1; m_code = c; m_busy = 1;
        end else begin
          m_str = k; m_busy = 2;
          if (k <= 2) m_undo = (m_undo < UNDO_DEPTH) ? m_undo + 1 : m_undo;
          else if (k == 3) m_undo = 0;
          else m_undo = m_undo - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_s, act_s;
    if (back) n_back++;
    if (m_live) begin
      exp_s = 5'b10000;
      exp_s = (m_str >= 0 && rst) ? (exp_s >> m_str) : 5'b00000;
      act_s = {small_add, seven_add, large_add, deck_add, back};
      chk("strobes", int'(act_s), int'(exp_s));
      chk("err", int'(err), int'(m_err && rst));
      chk("err_code", int'(err_code), m_code);
      chk("in_ready", int'(in_ready), int'(rst && m_busy == 0));
      if (m_busy == 0) chk("undo_cnt", int'(undo_cnt), m_undo);
    end
  end

  task automatic issue(input logic [1:0] c, input logic [3:0] r,
                       input logic [7:0] d, input logic [15:0] t);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    in_valid = 1'b1; in_cmd = c; in_rank = r; deck = d; total = t;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issue a command and check the T+1 response against literal values
  task automatic issue_expect(input string name, input logic [1:0] c, input logic [3:0] r,
                              input logic [7:0] d, input logic [15:0] t,
                              input int exp_strobes, input int exp_err, input int exp_code);
    issue(c, r, d, t);
    @(negedge clk);
    chk({name, "_strobes"}, int'({small_add, seven_add, large_add, deck_add, back}), exp_strobes);
    chk({name, "_err"}, int'(err), exp_err);
    if (exp_err != 0) chk({name, "_code"}, int'(err_code), exp_code);
  endtask

  initial begin
    int b0;
    // Reset hold
    repeat (3) @(negedge clk);
    chk("ready_in_reset", int'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);
    chk("undo_after_reset", int'(undo_cnt), 0);
    chk("code_after_reset", int'(err_code), 0);

    // Deck add from empty shoe: pulse at T+1, ready low T+1..T+2, high T+3
    issue_expect("deck_add", 2'd1, 4'd0, 8'd0, 16'd0, 5'b00010, 0, 0);
    chk("deck_ready_t1", int'(in_ready), 0);
    @(negedge clk);
    chk("deck_ready_t2", int'(in_ready), 0);
    chk("deck_pulse_t2", int'(deck_add), 0);
    @(negedge clk);
    chk("deck_ready_t3", int'(in_ready), 1);

    // Three cards, one per strobe class
    issue_expect("rank5", 2'd0, 4'd5, 8'd1, 16'd0, 5'b10000, 0, 0);
    issue_expect("rank8", 2'd0, 4'd8, 8'd1, 16'd1, 5'b01000, 0, 0);
    issue_expect("rank12", 2'd0, 4'd12, 8'd1, 16'd2, 5'b00100, 0, 0);
    repeat (2) @(negedge clk);
    chk("undo_three", int'(undo_cnt), 3);

    // Rejections
    issue_expect("shoe_full", 2'd0, 4'd3, 8'd1, 16'd52, 5'b00000, 1, 4);
    issue_expect("deck_nonzero", 2'd1, 4'd0, 8'd1, 16'd10, 5'b00000, 1, 5);
    issue_expect("no_deck", 2'd0, 4'd2, 8'd0, 16'd0, 5'b00000, 1, 3);
    issue_expect("reserved", 2'd3, 4'd5, 8'd1, 16'd0, 5'b00000, 1, 1);
    issue_expect("rank0", 2'd0, 4'd0, 8'd1, 16'd0, 5'b00000, 1, 2);
    issue_expect("rank14", 2'd0, 4'd14, 8'd1, 16'd0, 5'b00000, 1, 2);
    issue_expect("deck_max", 2'd1, 4'd0, 8'd8, 16'd0, 5'b00000, 1, 6);
    @(negedge clk);
    chk("code_held", int'(err_code), 6);

    // Last legal card of a two-deck shoe, then the first illegal one
    issue_expect("last_card", 2'd0, 4'd1, 8'd2, 16'd103, 5'b00100, 0, 0);
    issue_expect("past_last", 2'd0, 4'd1, 8'd2, 16'd104, 5'b00000, 1, 4);

    // Undo saturation and exhaustion
    issue_expect("clear_undo", 2'd1, 4'd0, 8'd1, 16'd0, 5'b00010, 0, 0);
    for (int i = 0; i < 6; i++) issue(2'd0, 4'd4, 8'd1, 16'(i));
    repeat (3) @(negedge clk);
    chk("undo_sat", int'(undo_cnt), UNDO_DEPTH);
    b0 = n_back;
    for (int i = 0; i < 4; i++) issue(2'd2, 4'd0, 8'd1, 16'd6);
    issue_expect("back_empty", 2'd2, 4'd0, 8'd1, 16'd6, 5'b00000, 1, 7);
    chk("back_pulses", n_back - b0, 4);
    chk("undo_empty", int'(undo_cnt), 0);

    // Reset during ISSUE aborts the card
    issue(2'd0, 4'd9, 8'd1, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_strobe", int'(seven_add), 0);
    chk("abort_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("abort_ready2", int'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", int'(in_ready), 1);
    chk("abort_undo", int'(undo_cnt), 0);

    // Random traffic, including values straddling the shoe limit
    for (int i = 0; i < 4000; i++) begin
      int d;
      @(posedge clk); #1;
      rst      = ($urandom_range(199) != 0);
      in_valid = ($urandom_range(9) < 7);
      in_cmd   = 2'($urandom_range(3));
      in_rank  = 4'($urandom_range(15));
      case ($urandom_range(3))
        0: d = 0;
        1: d = MAX_DECK - 1 + $urandom_range(2);
        default: d = $urandom_range(4);
      endcase
      deck = 8'(d);
      case ($urandom_range(4))
        0, 1: total = 16'd0;
        2: total = 16'(52 * d - 1);
        3: total = 16'(52 * d);
        default: total = 16'($urandom_range(600));
      endcase
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
